m_mem_resp: RTL and testbench

//  Memory responder: unified instruction/data memory slave on the far side of the CPU's memory port.

---
 rtl/m_mem_resp_pkg.sv | 28 ++
 rtl/m_mem_resp_if.sv | 23 ++
 rtl/m_mem_resp_lane.sv | 36 +++
 rtl/m_mem_resp.sv | 133 +++++++++++++
 tb/tb_m_mem_resp.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/m_mem_resp_pkg.sv
// Shared types for the memory responder: transaction stage encoding and RV32 funct3 codes.
package m_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } stage_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte offset after forcing the address to the natural alignment of the access size.
  function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] a);
    logic [1:0] off;
    case (f3)
      F3_B, F3_BU: off = a;
      F3_H, F3_HU: off = {a[1], 1'b0};
      default:     off = 2'b00;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/m_mem_resp_if.sv
// Request/response handshake bundle between the CPU memory port (master) and the responder (slave).
interface m_mem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/m_mem_resp_lane.sv
// Combinational lane logic: store byte/half merge into the old word and load extract with sign/zero extension.
module m_mem_lane
  import m_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [31:0] shifted_s;

  always_comb begin
    merged_o = old_i;
    case (funct3_i)
      F3_B:    merged_o[{off_i, 3'b000} +: 8]        = wdata_i[7:0];
      F3_H:    merged_o[{off_i[1], 4'b0000} +: 16]   = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

  always_comb begin
    shifted_s = old_i >> {off_i, 3'b000};
    load_o    = old_i;
    case (funct3_i)
      F3_B:    load_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_BU:   load_o = {24'h000000, shifted_s[7:0]};
      F3_H:    load_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_HU:   load_o = {16'h0000, shifted_s[15:0]};
      default: load_o = old_i;
    endcase
  end

endmodule

// File: rtl/m_mem_resp.sv
// Unified I/D memory responder with LATENCY wait states and RV32 byte/half/word accesses.
// Optional build macro MEM_RESP_ALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module m_mem_resp
  import m_mem_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = "asm.bin"
) (
  input logic          clk,
  input logic          rst,
  m_mem_resp_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem_q [DEPTH];

  stage_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic          range_ok_s;
  logic          err_s;
  logic [1:0]    off_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   old_s;
  logic [31:0]   merged_s;
  logic [31:0]   load_s;

  assign range_ok_s = (addr_q[31:AW+2] == '0);
  assign idx_s      = addr_q[AW+1:2];
  assign old_s      = mem_q[idx_s];
  assign off_s      = lane_off(f3_q, addr_q[1:0]);

`ifdef MEM_RESP_ALIGN_CHECK_EN
  logic misalign_s;
  always_comb begin
    case (f3_q)
      F3_B, F3_BU: misalign_s = 1'b0;
      F3_H, F3_HU: misalign_s = addr_q[0];
      default:     misalign_s = (addr_q[1:0] != 2'b00);
    endcase
  end
  assign err_s = !range_ok_s || misalign_s;
`else
  assign err_s = !range_ok_s;
`endif

  m_mem_lane u_lane (
    .funct3_i (f3_q),
    .off_i    (off_s),
    .old_i    (old_s),
    .wdata_i  (wdata_q),
    .merged_o (merged_s),
    .load_o   (load_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = (LATENCY == 0) ? ACCESS : WAIT;
          cnt_d   = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'(LATENCY - 1)) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      f3_q    <= 3'b000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        f3_q    <= bus.req_funct3;
        wdata_q <= bus.req_wdata;
      end
      if (state_q == ACCESS) begin
        rdata_q <= (we_q || err_s) ? 32'h0 : load_s;
        err_q   <= err_s;
      end
    end
  end

  // Array is never cleared; a reset on the ACCESS edge cancels the write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ACCESS && we_q && !err_s) begin
      mem_q[idx_s] <= merged_s;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_m_mem_resp.sv
// Self-checking bench for m_mem_resp: directed scenarios plus randomized traffic against a byte-array model.
module tb_m_mem_resp;
  import m_mem_pkg::*;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;
`ifdef MEM_RESP_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] ref_mem [DEPTH*4];

  m_mem_resp_if bus();

  m_mem_resp #(.DEPTH(DEPTH), .LATENCY(LATENCY), .INIT_FILE("")) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian byte array, access size from funct3[1:0], low bits forced down to alignment.
  task automatic ref_access(input logic we, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int unsigned sz;
    int unsigned base;
    logic [31:0] v;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    er = (a[31:2] >= 30'(DEPTH)) || (ALIGN && ((a % sz) != 0));
    base = a - (a % sz);
    rd = 32'h0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < int'(sz); i++) ref_mem[base + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < int'(sz); i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8 * sz)) - 32'h1);
        rd = v;
      end
    end
  endtask

  task automatic xact(input logic we, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    logic [31:0] held_rd;
    logic        held_er;
    int          n;
    ref_access(we, a, f3, wd, exp_rd, exp_er);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = a;
    bus.req_funct3 = f3;
    bus.req_wdata  = wd;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 32'(n < 100), 32'h1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_addr   = $urandom();
    bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_wdata  = $urandom();
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency_edges", 32'(n), 32'(LATENCY + 2));
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("rsp_err", 32'(bus.rsp_err), 32'(exp_er));
    held_rd = bus.rsp_rdata;
    held_er = bus.rsp_err;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h0;
      @(negedge clk);
      chk("hold_valid", 32'(bus.rsp_valid), 32'h1);
      chk("hold_rdata", bus.rsp_rdata, held_rd);
      chk("hold_err", 32'(bus.rsp_err), 32'(held_er));
      chk("hold_req_ready", 32'(bus.req_ready), 32'h0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("done_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("done_req_ready", 32'(bus.req_ready), 32'h1);
    rd = held_rd;
    er = held_er;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] w0;
    logic        we;
    logic [31:0] a;
    logic [2:0]  f3;
    int          hold;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_funct3 = 3'b000;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);

    for (int w = 0; w < 16; w++) xact(1'b1, 32'(w * 4), F3_W, $urandom(), 0, rd, er);

    xact(1'b1, 32'h10, F3_W, 32'hDEADBEEF, 0, rd, er);
    chk("t1_sw_rdata", rd, 32'h0);
    xact(1'b0, 32'h10, F3_W, 32'h0, 0, rd, er);
    chk("t1_lw", rd, 32'hDEADBEEF);

    xact(1'b1, 32'h11, F3_B, 32'h0000007F, 0, rd, er);
    xact(1'b0, 32'h10, F3_W, 32'h0, 0, rd, er);
    chk("t2_lw", rd, 32'hDEAD7FEF);
    xact(1'b0, 32'h13, F3_B, 32'h0, 0, rd, er);
    chk("t2_lb", rd, 32'hFFFFFFDE);
    xact(1'b0, 32'h13, F3_BU, 32'h0, 0, rd, er);
    chk("t2_lbu", rd, 32'h000000DE);

    xact(1'b1, 32'h22, F3_H, 32'h00008001, 0, rd, er);
    xact(1'b0, 32'h22, F3_H, 32'h0, 0, rd, er);
    chk("t3_lh", rd, 32'hFFFF8001);
    xact(1'b0, 32'h22, F3_HU, 32'h0, 0, rd, er);
    chk("t3_lhu", rd, 32'h00008001);
    xact(1'b0, 32'h20, F3_W, 32'h0, 0, rd, er);
    chk("t3_lw_hi", {16'h0000, rd[31:16]}, 32'h00008001);

    xact(1'b0, 32'(DEPTH * 4), F3_W, 32'h0, 0, rd, er);
    chk("t4_oor_err", 32'(er), 32'h1);
    chk("t4_oor_rdata", rd, 32'h0);
    xact(1'b0, 32'h0, F3_W, 32'h0, 0, w0, er);
    xact(1'b1, 32'(DEPTH * 4), F3_W, 32'h12345678, 0, rd, er);
    chk("t4_oor_sw_err", 32'(er), 32'h1);
    xact(1'b0, 32'h0, F3_W, 32'h0, 0, rd, er);
    chk("t4_word0_kept", rd, w0);

    xact(1'b0, 32'h10, F3_W, 32'h0, 5, rd, er);
    chk("t5_lw", rd, 32'hDEAD7FEF);
    repeat (2) @(negedge clk);
    chk("t5_single_completion", 32'(bus.rsp_valid), 32'h0);

    // Reset while waiting: the store must vanish.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h0;
    bus.req_funct3 = F3_W; bus.req_wdata = 32'h1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_idle_ready", 32'(bus.req_ready), 32'h1);
    chk("t6_no_valid", 32'(bus.rsp_valid), 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_valid_stays_low", 32'(bus.rsp_valid), 32'h0);
    end
    xact(1'b0, 32'h0, F3_W, 32'h0, 0, rd, er);
    chk("t6_lw_prior", rd, w0);

    // Reset landing on the edge that leaves ACCESS.
    xact(1'b0, 32'h4, F3_W, 32'h0, 0, w0, er);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h4;
    bus.req_funct3 = F3_W; bus.req_wdata = ~w0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (LATENCY) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6b_no_valid", 32'(bus.rsp_valid), 32'h0);
    xact(1'b0, 32'h4, F3_W, 32'h0, 0, rd, er);
    chk("t6b_write_dropped", rd, w0);

    xact(1'b0, 32'h2, F3_W, 32'h0, 0, rd, er);
    chk("align_lw2_err", 32'(er), 32'(ALIGN));

    for (int k = 0; k < 200; k++) begin
      we = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) a = $urandom() | 32'h00000100;
      else a = 32'($urandom_range(0, 63));
      if (we) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 7));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      xact(we, a, f3, $urandom(), hold, rd, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
